// File: rtl/dds_dac_spi_if.sv
// Sample-in / DAC-out bundle of the DDS-to-DAC serial driver.
// The master modport is the DDS side; the slave modport is the driver.
interface dds_dac_spi_if #(
  parameter int DATA_W = 10
);
  logic [DATA_W-1:0] SampleIn;
  logic              SampleValid;
  logic              Busy;
  logic              DacCs_n;
  logic              DacSclk;
  logic              DacSdo;
  logic [7:0]        Overrun;

  modport master (
    output SampleIn, SampleValid,
    input  Busy, DacCs_n, DacSclk, DacSdo, Overrun
  );

  modport slave (
    input  SampleIn, SampleValid,
    output Busy, DacCs_n, DacSclk, DacSdo, Overrun
  );
endinterface

// File: rtl/dds_dac_spi.sv
// Serial DAC driver: signed DDS sample -> offset binary, left-justified frame,
// shifted out MSB-first on a mode-0 SPI link, with a one-entry holding buffer.
module dds_dac_spi #(
  parameter int DATA_W   = 10,
  parameter int FRAME_W  = 16,
  parameter int SCLK_DIV = 2
) (
  input logic           Clock,
  input logic           Rst_n,
  dds_dac_spi_if.slave  bus
);
  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int CNT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t             r_state;
  logic [DATA_W-1:0]  r_buf;
  logic               r_buf_full;
  logic [FRAME_W-1:0] r_shift;
  logic [DIV_W-1:0]   r_div;
  logic [CNT_W-1:0]   r_bit;
  logic               r_cs_n;
  logic               r_sclk;
  logic               r_sdo;
  logic               r_busy;
  logic [7:0]         r_overrun;

  logic               w_drain;
  logic               w_wr;
  logic               w_drop;
  logic               w_buf_full_next;
  logic               w_busy_next;
  logic               w_div_end;
  logic [DATA_W-1:0]  w_offset;
  logic [FRAME_W-1:0] w_frame;

  assign w_offset = {~r_buf[DATA_W-1], r_buf[DATA_W-2:0]};

  generate
    if (FRAME_W > DATA_W) begin : g_pad
      assign w_frame = {w_offset, {(FRAME_W-DATA_W){1'b0}}};
    end else begin : g_nopad
      assign w_frame = w_offset;
    end
  endgenerate

  assign w_div_end = (r_div == DIV_W'(SCLK_DIV - 1));

  // A sample arriving in the very cycle the buffer drains is kept, not dropped.
  always_comb begin
    w_drain         = (r_state == IDLE) && r_buf_full;
    w_wr            = bus.SampleValid && (!r_buf_full || w_drain);
    w_drop          = bus.SampleValid && !w_wr;
    w_buf_full_next = w_wr ? 1'b1 : (w_drain ? 1'b0 : r_buf_full);
    w_busy_next     = w_buf_full_next;
    if (r_state == IDLE)
      w_busy_next = w_buf_full_next || w_drain;
    else if (r_state != HOLD)
      w_busy_next = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (!Rst_n) begin
      r_state    <= IDLE;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_shift    <= '0;
      r_div      <= '0;
      r_bit      <= '0;
      r_cs_n     <= 1'b1;
      r_sclk     <= 1'b0;
      r_sdo      <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= '0;
    end else begin
      if (w_wr)
        r_buf <= bus.SampleIn;
      r_buf_full <= w_buf_full_next;
      r_busy     <= w_busy_next;
      if (w_drop && (r_overrun != 8'hFF))
        r_overrun <= r_overrun + 8'd1;

      case (r_state)
        IDLE: begin
          r_cs_n <= 1'b1;
          r_sclk <= 1'b0;
          r_sdo  <= 1'b0;
          if (r_buf_full) begin
            r_shift <= w_frame;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_cs_n  <= 1'b0;
          r_sclk  <= 1'b0;
          r_sdo   <= r_shift[FRAME_W-1];
          r_div   <= '0;
          r_bit   <= '0;
          r_state <= SHIFT;
        end
        SHIFT: begin
          if (w_div_end) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            // Falling edge: advance so the next bit is centred on the next rise.
            if (r_sclk) begin
              r_shift <= r_shift << 1;
              r_sdo   <= r_shift[FRAME_W-2];
              r_bit   <= r_bit + CNT_W'(1);
              if (r_bit == CNT_W'(FRAME_W - 1))
                r_state <= HOLD;
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        HOLD: begin
          r_cs_n  <= 1'b0;
          r_sclk  <= 1'b0;
          r_sdo   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.Busy    = r_busy;
  assign bus.DacCs_n = r_cs_n;
  assign bus.DacSclk = r_sclk;
  assign bus.DacSdo  = r_sdo;
  assign bus.Overrun = r_overrun;
endmodule

// File: doc/dds_dac_spi.md
# dds_dac_spi

Serial DAC driver sitting directly downstream of the DDS sine generator. Accepts one signed DDS sample per `SampleValid` strobe, converts it to offset binary, left-justifies it in a fixed-width frame and shifts it out MSB-first over a 3-wire SPI link (mode 0) to an external DAC. A single-entry holding buffer absorbs one sample arriving mid-frame. Samples arriving while the buffer is full are dropped and counted.

## Interface
- `DATA_W`, 10: width of the signed input sample.
- `FRAME_W`, 16: SPI frame length in bits. Must satisfy `FRAME_W >= DATA_W`.
- `SCLK_DIV`, 2: `Clock` cycles per `DacSclk` half-period. Must be ≥ 1.

- `Clock`  in  1  system clock; all logic is on the rising edge.
- `Rst_n`  in  1  reset, synchronous and active-low.
- `SampleIn`  in  DATA_W  signed two's-complement sample from the DDS.
- `SampleValid`  in  1  one-cycle strobe: `SampleIn` is valid this cycle.
- `Busy`  out  1  high when state ≠ IDLE or the buffer is full.
- `DacCs_n`  out  1  DAC chip select, active-low.
- `DacSclk`  out  1  SPI clock. Idles low (CPOL=0).
- `DacSdo`  out  1  serial data. DAC samples it on the `DacSclk` rising edge.
- `Overrun`  out  8  count of dropped samples. Saturates at 255.

## Operation
- **Conversion**
  - offset = {~SampleIn[DATA_W-1], SampleIn[DATA_W-2:0]}.
  - frame = {offset, (FRAME_W-DATA_W) zeros}, sent MSB first.
- **Buffer** (one entry)
  - Write when `SampleValid` is high and either (a) the buffer is empty, or (b) the buffer is being drained into the shifter in the same cycle.
  - Otherwise the sample is dropped and `Overrun` increments, holding at 255.
- **FSM**, states IDLE, SETUP, SHIFT, HOLD:
  - **IDLE**: `DacCs_n`=1, `DacSclk`=0. If the buffer is full, load the shift register from the buffer, mark the buffer empty, and go to SETUP.
  - **SETUP** (1 cycle): `DacCs_n`=0, `DacSclk`=0, `DacSdo`=frame MSB. Go to SHIFT.
  - **SHIFT**:
    - A divider counts `SCLK_DIV` cycles per half-period.
    - `DacSclk` rises, then falls. On each falling edge the shift register advances and `DacSdo` presents the next bit.
    - After the FRAME_W-th falling edge, go to HOLD.
  - **HOLD** (1 cycle): `DacCs_n`=0, `DacSclk`=0. Go to IDLE. IDLE holds `DacCs_n`=1 for at least 1 cycle before the next SETUP.
- **Outputs**: all are registered. `DacSdo` is 0 whenever `DacCs_n`=1.
- **Frame time**: exactly 2·SCLK_DIV·FRAME_W + 3 cycles from SETUP entry to the next possible SETUP entry. With defaults this is 67 cycles.
- **Input rate**: sustained input above one sample per frame time produces drops. This is legal, and it is counted.

## Timing
- **Reset** (`Rst_n`=0 at an edge) forces:
  - state IDLE, buffer empty, `Overrun`=0
  - `DacCs_n`=1, `DacSclk`=0, `DacSdo`=0, `Busy`=0
- **Reset mid-frame** aborts the frame immediately, with the same values as above. There is no partial-frame completion.
- **Latency** (idle, empty buffer): for a `SampleValid` sampled at edge E0:
  - buffer is written at E0
  - `DacCs_n` falls at E1+1 (SETUP entered at E1)
  - first `DacSclk` rise at E1+1+SCLK_DIV
- **`Busy`** rises at E0 and falls at the edge entering IDLE with the buffer empty.
- **Simultaneous drain and arrival**: `SampleValid` in the IDLE cycle that drains a full buffer stores the new sample. It is not a drop.
- **Mid-frame arrival**: `SampleValid` during SETUP, SHIFT or HOLD:
  - buffer empty: store the sample
  - buffer full: drop the sample and increment `Overrun`
- **Per-bit timing**: each bit is stable for 2·SCLK_DIV cycles and is centred on its `DacSclk` rising edge.

## Test plan
- **Midscale**: reset, then `SampleIn`=0x000 pulse → one frame of 16 bits = 0x8000. `DacCs_n` low 2·2·16+2 = 66 cycles. `Overrun`=0.
- **Extremes**: `SampleIn`=0x200 (−512), then after that frame ends 0x1FF (+511) → frames 0x0000, then 0xFFC0. Frames are separated by ≥1 cycle with `DacCs_n`=1.
- **Overrun**: SampleValid on 3 consecutive cycles with values 0x001, 0x002, 0x003 → frames for 0x001 (0x8040) and 0x002 (0x8080) only. `Overrun`=1.
- **DDS cadence**: one sample every 10 cycles for 1000 samples with defaults → every 7th-ish sample is transmitted. `Overrun` saturates at 255 and never wraps.
- **Reset mid-frame**: assert `Rst_n`=0 for 1 cycle at the 8th `DacSclk` rise → next cycle `DacCs_n`=1, `DacSclk`=0, `Busy`=0, `Overrun`=0. The next sample produces a complete, correct frame.
- **Divider**: `SCLK_DIV`=1, `FRAME_W`=10, `SampleIn`=0x155 → frame 0x355 (11_0101_0101). `DacSclk` period is 2 cycles. Total frame time is 23 cycles.
